gtp_link_manager: RTL and testbench

Per-link bring-up and recovery sequencer for the 4-lane GTP back end. It drives each lane's powerdown input and watches the lane's link_up and link_error outputs. It retrains lanes that fail to come up or that drop, and declares a lane failed after a bounded number of retries. It sits between the board-level control/status logic and the quad back end's i_linkN_powerdown, o_linkN_up and o_linkN_error ports.

---
 rtl/gtp_link_manager.sv | 188 ++++++++++++++++++
 tb/tb_gtp_link_manager.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/gtp_link_manager.sv
// Per-lane bring-up and recovery sequencer for the 4-lane GTP back end.
// Each lane runs an independent FSM: OFF -> TRAIN -> UP, with timed
// power-down retries (PDOWN) and a sticky FAILED state after too many retries.
// All outputs are registered decodes of the current lane state, so they lag
// the state by one clock.
module gtp_link_manager #(
  parameter int UP_TIMEOUT = 65535,
  parameter int PD_CYCLES  = 255,
  parameter int MAX_RETRY  = 7,
  parameter int ERR_FILTER = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_gtp_init_done,
  input  logic [3:0]  i_link_en,
  input  logic [3:0]  i_link_up,
  input  logic [3:0]  i_link_error,
  output logic [3:0]  o_link_powerdown,
  output logic [3:0]  o_link_ok,
  output logic [3:0]  o_link_failed,
  output logic [15:0] o_retry_cnt,
  output logic        o_retrain
);

  // The timer is shared by TRAIN and PDOWN, so it must hold either limit.
  localparam int UP_TW = $clog2(UP_TIMEOUT);
  localparam int PD_TW = $clog2(PD_CYCLES);
  localparam int TW_A  = (UP_TW > PD_TW) ? UP_TW : PD_TW;
  localparam int TW    = (TW_A < 1) ? 1 : TW_A;
  localparam int FW    = $clog2(ERR_FILTER + 1);

  localparam logic [TW-1:0] UP_LAST   = TW'(UP_TIMEOUT - 1);
  localparam logic [TW-1:0] PD_LAST   = TW'(PD_CYCLES - 1);
  localparam logic [TW-1:0] TMR_ZERO  = TW'(0);
  localparam logic [TW-1:0] TMR_ONE   = TW'(1);
  localparam logic [FW-1:0] FILT_LIM  = FW'(ERR_FILTER);
  localparam logic [FW-1:0] FILT_ZERO = FW'(0);
  localparam logic [FW-1:0] FILT_ONE  = FW'(1);
  localparam logic [3:0]    RETRY_LIM = 4'(MAX_RETRY);

  typedef enum logic [2:0] {
    S_OFF    = 3'd0,
    S_TRAIN  = 3'd1,
    S_UP     = 3'd2,
    S_PDOWN  = 3'd3,
    S_FAILED = 3'd4
  } state_t;

  state_t        state_q [4];
  state_t        state_d [4];
  logic [TW-1:0] timer_q [4];
  logic [TW-1:0] timer_d [4];
  logic [3:0]    retry_q [4];
  logic [3:0]    retry_d [4];
  logic [FW-1:0] filt_q  [4];
  logic [FW-1:0] filt_d  [4];
  logic [3:0]    retry_req;
  logic [3:0]    pdown_entry;

  logic [3:0]    pd_q;
  logic [3:0]    ok_q;
  logic [3:0]    failed_q;
  logic [15:0]   retry_out_q;
  logic          retrain_q;

  // Next-state, timer, retry counter and error filter for every lane.
  always_comb begin
    for (int n = 0; n < 4; n++) begin
      state_d[n]     = state_q[n];
      timer_d[n]     = timer_q[n];
      retry_d[n]     = retry_q[n];
      filt_d[n]      = filt_q[n];
      retry_req[n]   = 1'b0;
      pdown_entry[n] = 1'b0;

      if (!i_gtp_init_done || !i_link_en[n]) begin
        state_d[n] = S_OFF;
      end else begin
        case (state_q[n])
          S_OFF: begin
            state_d[n] = S_TRAIN;
            timer_d[n] = TMR_ZERO;
            retry_d[n] = 4'd0;
            filt_d[n]  = FILT_ZERO;
          end
          S_TRAIN: begin
            if (i_link_up[n] && !i_link_error[n]) begin
              state_d[n] = S_UP;
              filt_d[n]  = FILT_ZERO;
            end else if (timer_q[n] == UP_LAST) begin
              retry_req[n] = 1'b1;
            end else begin
              timer_d[n] = timer_q[n] + TMR_ONE;
            end
          end
          S_UP: begin
            if (!i_link_up[n]) begin
              retry_req[n] = 1'b1;
            end else if (i_link_error[n]) begin
              if ((filt_q[n] + FILT_ONE) == FILT_LIM) begin
                retry_req[n] = 1'b1;
              end else begin
                filt_d[n] = filt_q[n] + FILT_ONE;
              end
            end else begin
              filt_d[n] = FILT_ZERO;
            end
          end
          S_PDOWN: begin
            if (timer_q[n] == PD_LAST) begin
              state_d[n] = S_TRAIN;
              timer_d[n] = TMR_ZERO;
            end else begin
              timer_d[n] = timer_q[n] + TMR_ONE;
            end
          end
          S_FAILED: begin
            state_d[n] = S_FAILED;
          end
          default: begin
            state_d[n] = S_OFF;
          end
        endcase
      end

      // Retry decision: give up once the budget is spent, else power-cycle.
      if (retry_req[n]) begin
        if (retry_q[n] == RETRY_LIM) begin
          state_d[n] = S_FAILED;
        end else begin
          state_d[n]     = S_PDOWN;
          retry_d[n]     = retry_q[n] + 4'd1;
          timer_d[n]     = TMR_ZERO;
          pdown_entry[n] = 1'b1;
        end
      end else begin
        pdown_entry[n] = 1'b0;
      end
    end
  end

  // Lane state registers plus registered output decodes of the current state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int n = 0; n < 4; n++) begin
        state_q[n] <= S_OFF;
        timer_q[n] <= TMR_ZERO;
        retry_q[n] <= 4'd0;
        filt_q[n]  <= FILT_ZERO;
      end
      pd_q        <= 4'b1111;
      ok_q        <= 4'b0000;
      failed_q    <= 4'b0000;
      retry_out_q <= 16'd0;
      retrain_q   <= 1'b0;
    end else begin
      for (int n = 0; n < 4; n++) begin
        state_q[n] <= state_d[n];
        timer_q[n] <= timer_d[n];
        retry_q[n] <= retry_d[n];
        filt_q[n]  <= filt_d[n];
        retry_out_q[4*n +: 4] <= retry_q[n];
        case (state_q[n])
          S_TRAIN: begin
            pd_q[n] <= 1'b0; ok_q[n] <= 1'b0; failed_q[n] <= 1'b0;
          end
          S_UP: begin
            pd_q[n] <= 1'b0; ok_q[n] <= 1'b1; failed_q[n] <= 1'b0;
          end
          S_FAILED: begin
            pd_q[n] <= 1'b1; ok_q[n] <= 1'b0; failed_q[n] <= 1'b1;
          end
          default: begin
            pd_q[n] <= 1'b1; ok_q[n] <= 1'b0; failed_q[n] <= 1'b0;
          end
        endcase
      end
      retrain_q <= |pdown_entry;
    end
  end

  assign o_link_powerdown = pd_q;
  assign o_link_ok        = ok_q;
  assign o_link_failed    = failed_q;
  assign o_retry_cnt      = retry_out_q;
  assign o_retrain        = retrain_q;

endmodule

// File: tb/tb_gtp_link_manager.sv
// Scoreboard bench for gtp_link_manager with short timers.
// Expected output values are queued with the cycle at which they must appear
// and checked by a monitor on the falling clock edge.
module tb_gtp_link_manager;

  logic        clk;
  logic        rst;
  logic        i_gtp_init_done;
  logic [3:0]  i_link_en;
  logic [3:0]  i_link_up;
  logic [3:0]  i_link_error;
  logic [3:0]  o_link_powerdown;
  logic [3:0]  o_link_ok;
  logic [3:0]  o_link_failed;
  logic [15:0] o_retry_cnt;
  logic        o_retrain;

  gtp_link_manager #(
    .UP_TIMEOUT(16),
    .PD_CYCLES (4),
    .MAX_RETRY (2),
    .ERR_FILTER(3)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .i_gtp_init_done (i_gtp_init_done),
    .i_link_en       (i_link_en),
    .i_link_up       (i_link_up),
    .i_link_error    (i_link_error),
    .o_link_powerdown(o_link_powerdown),
    .o_link_ok       (o_link_ok),
    .o_link_failed   (o_link_failed),
    .o_retry_cnt     (o_retry_cnt),
    .o_retrain       (o_retrain)
  );

  localparam int SEL_PD = 0, SEL_OK = 1, SEL_FAIL = 2, SEL_RETRY = 3, SEL_RT = 4;

  typedef struct {
    int          cyc;
    int          sel;
    logic [15:0] exp;
    logic [15:0] mask;
    string       tag;
  } sb_t;

  sb_t sb[$];
  int  cyc = 0;
  int  n_checks = 0;
  int  n_pass = 0;
  int  rt_cnt = 0;
  int  base;
  int  rt0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle index: number of rising edges seen so far.
  always @(posedge clk) cyc <= cyc + 1;

  // Count o_retrain pulses.
  always @(posedge clk) if (o_retrain) rt_cnt <= rt_cnt + 1;

  task automatic check_val(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
  endtask

  task automatic push(input int dt, input int sel, input logic [15:0] exp,
                      input logic [15:0] mask, input string tag);
    sb_t e;
    e.cyc = cyc + dt; e.sel = sel; e.exp = exp; e.mask = mask; e.tag = tag;
    sb.push_back(e);
  endtask

  function automatic logic [15:0] pick(input int sel);
    case (sel)
      SEL_PD:    pick = {12'd0, o_link_powerdown};
      SEL_OK:    pick = {12'd0, o_link_ok};
      SEL_FAIL:  pick = {12'd0, o_link_failed};
      SEL_RETRY: pick = o_retry_cnt;
      SEL_RT:    pick = {15'd0, o_retrain};
      default:   pick = 16'hFFFF;
    endcase
  endfunction

  // Scoreboard monitor: compare every entry due in this cycle, then drop it.
  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc == cyc) begin
        check_val(sb[i].tag, pick(sb[i].sel) & sb[i].mask, sb[i].exp & sb[i].mask);
        sb.delete(i);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst = 1'b0; i_gtp_init_done = 1'b1; i_link_en = 4'b0000;
    i_link_up = 4'b0000; i_link_error = 4'b0000;
    #1 rst = 1'b1;
    #2;
    check_val("rst_pd",      {12'd0, o_link_powerdown}, 16'h000F);
    check_val("rst_ok",      {12'd0, o_link_ok},        16'h0000);
    check_val("rst_failed",  {12'd0, o_link_failed},    16'h0000);
    check_val("rst_retry",   o_retry_cnt,               16'h0000);
    check_val("rst_retrain", {15'd0, o_retrain},        16'h0000);
    tick(2);
    rst = 1'b0;
    tick(2);

    // 1: lane 0 never links; two retries then FAILED.
    rt0 = rt_cnt;
    i_link_en = 4'b0001;
    for (int t = 0; t < 56; t++) begin
      logic pd_e;
      pd_e = ((t >= 16) && (t < 20)) || ((t >= 36) && (t < 40));
      push(2 + t, SEL_PD, {15'd0, pd_e}, 16'h0001, "t1_pd0");
    end
    push(57, SEL_FAIL,  16'h0000, 16'h000F, "t1_failed_pre");
    push(58, SEL_FAIL,  16'h0001, 16'h000F, "t1_failed");
    push(58, SEL_RETRY, 16'h0002, 16'hFFFF, "t1_retry");
    push(30, SEL_PD,    16'h000E, 16'h000E, "t1_pd_idle");
    push(30, SEL_OK,    16'h0000, 16'h000F, "t1_ok");
    push(17, SEL_RT,    16'h0001, 16'h0001, "t1_retrain_a");
    push(18, SEL_RT,    16'h0000, 16'h0001, "t1_retrain_gap");
    push(37, SEL_RT,    16'h0001, 16'h0001, "t1_retrain_b");
    tick(60);
    check_val("t1_retrain_cnt", 16'(rt_cnt - rt0), 16'd2);

    // Disable: failed clears, retry count stays visible.
    i_link_en = 4'b0000;
    push(2, SEL_FAIL,  16'h0000, 16'h000F, "t1_off_failed");
    push(3, SEL_RETRY, 16'h0002, 16'hFFFF, "t1_off_retry");
    tick(3);

    // 2: all lanes train and come up together.
    rt0 = rt_cnt;
    i_link_en = 4'b1111;
    push(2, SEL_RETRY, 16'h0000, 16'hFFFF, "t2_retry_clr");
    push(2, SEL_PD,    16'h0000, 16'h000F, "t2_pd_train");
    push(6, SEL_OK,    16'h0000, 16'h000F, "t2_ok_pre");
    push(7, SEL_OK,    16'h000F, 16'h000F, "t2_ok");
    tick(5);
    i_link_up = 4'b1111;
    tick(5);
    check_val("t2_no_retrain", 16'(rt_cnt - rt0), 16'd0);

    // 3: lane 2 error bursts 2-on, 1-off, 3-on.
    i_link_error = 4'b0100;
    push(5,  SEL_RETRY, 16'h0000, 16'h0F00, "t3_retry_hold");
    push(5,  SEL_RT,    16'h0000, 16'h0001, "t3_no_rt");
    push(6,  SEL_PD,    16'h0000, 16'h0004, "t3_pd_up");
    push(6,  SEL_RT,    16'h0001, 16'h0001, "t3_retrain");
    for (int t = 7; t <= 10; t++) push(t, SEL_PD, 16'h0004, 16'h0004, "t3_pd_hi");
    push(7,  SEL_RETRY, 16'h0100, 16'h0F00, "t3_retry");
    push(7,  SEL_OK,    16'h000B, 16'h000F, "t3_ok");
    push(11, SEL_PD,    16'h0000, 16'h0004, "t3_pd_train");
    push(12, SEL_OK,    16'h000F, 16'h000F, "t3_ok_back");
    tick(2);
    i_link_error = 4'b0000;
    tick(1);
    i_link_error = 4'b0100;
    tick(3);
    i_link_error = 4'b0000;
    tick(9);

    // 4: lane 1 link_up glitch.
    i_link_up = 4'b1101;
    push(1, SEL_RT,    16'h0001, 16'h0001, "t4_retrain");
    push(2, SEL_OK,    16'h000D, 16'h000F, "t4_ok");
    push(2, SEL_PD,    16'h0002, 16'h000F, "t4_pd");
    push(2, SEL_RETRY, 16'h0110, 16'hFFFF, "t4_retry");
    push(7, SEL_OK,    16'h000F, 16'h000F, "t4_ok_back");
    tick(1);
    i_link_up = 4'b1111;
    tick(9);

    // 5: init_done drop forces all lanes OFF.
    i_gtp_init_done = 1'b0;
    push(1, SEL_OK,    16'h000F, 16'h000F, "t5_ok_pre");
    push(2, SEL_OK,    16'h0000, 16'h000F, "t5_ok_off");
    push(2, SEL_PD,    16'h000F, 16'h000F, "t5_pd_off");
    push(2, SEL_RETRY, 16'h0110, 16'hFFFF, "t5_retry_kept");
    tick(3);
    i_gtp_init_done = 1'b1;
    push(2, SEL_PD,    16'h0000, 16'h000F, "t5_pd_train");
    push(2, SEL_RETRY, 16'h0000, 16'hFFFF, "t5_retry_clr");
    push(3, SEL_OK,    16'h000F, 16'h000F, "t5_ok_back");
    tick(7);

    // 6: lane 0 fails, recovers via en toggle, then async reset mid-PDOWN.
    i_link_up = 4'b1110;
    push(41, SEL_FAIL,  16'h0000, 16'h000F, "t6_failed_pre");
    push(42, SEL_FAIL,  16'h0001, 16'h000F, "t6_failed");
    push(42, SEL_RETRY, 16'h0002, 16'h000F, "t6_retry");
    push(42, SEL_OK,    16'h000E, 16'h000F, "t6_ok");
    tick(45);
    i_link_en = 4'b1110;
    push(2, SEL_FAIL, 16'h0000, 16'h000F, "t6_failed_clr");
    push(2, SEL_PD,   16'h0001, 16'h0001, "t6_pd_off");
    tick(3);
    i_link_en = 4'b1111;
    push(1,  SEL_PD,    16'h0001, 16'h0001, "t6_pd_wait");
    push(2,  SEL_PD,    16'h0000, 16'h0001, "t6_pd_low");
    push(2,  SEL_RETRY, 16'h0000, 16'h000F, "t6_retry_clr");
    push(17, SEL_RT,    16'h0001, 16'h0001, "t6_retrain");
    push(19, SEL_PD,    16'h0001, 16'h0001, "t6_pd_pdown");
    push(19, SEL_OK,    16'h000E, 16'h000F, "t6_ok_pre_rst");
    tick(19);
    #2 rst = 1'b1;
    #1;
    check_val("t6_rst_pd",      {12'd0, o_link_powerdown}, 16'h000F);
    check_val("t6_rst_ok",      {12'd0, o_link_ok},        16'h0000);
    check_val("t6_rst_failed",  {12'd0, o_link_failed},    16'h0000);
    check_val("t6_rst_retry",   o_retry_cnt,               16'h0000);
    check_val("t6_rst_retrain", {15'd0, o_retrain},        16'h0000);
    tick(2);
    rst = 1'b0;
    tick(3);

    check_val("sb_drain", 16'(sb.size()), 16'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
